// File: rtl/dcache_flush_unit.sv
// Dcache flush walker: visits every set, writes back dirty ways, invalidates
// the set, and acknowledges the requester once the last set is done.
module dcache_flush_unit #(
   parameter int NUM_SETS = 256,
   parameter int NUM_WAYS = 8,
   localparam int IDX_W = $clog2(NUM_SETS),
   localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clr_i,
   input  logic                flush_i,
   output logic                flush_ack_o,
   output logic                busy_o,
   output logic                tag_req_o,
   input  logic                tag_gnt_i,
   output logic [IDX_W-1:0]    tag_idx_o,
   input  logic [NUM_WAYS-1:0] valid_i,
   input  logic [NUM_WAYS-1:0] dirty_i,
   output logic                wb_req_o,
   input  logic                wb_gnt_i,
   output logic [WAY_W-1:0]    wb_way_o,
   input  logic                wb_done_i,
   output logic                inv_o,
   output logic [NUM_WAYS-1:0] inv_way_mask_o
);

   typedef enum logic [2:0] {
      IDLE, READ_TAG, WAIT_TAG, WB_REQ, WB_WAIT, INVALIDATE, ACK, DONE
   } state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    cnt_q, cnt_d;
   logic [NUM_WAYS-1:0] dmask_q, dmask_d;
   logic [NUM_WAYS-1:0] vmask_q, vmask_d;

   function automatic logic [WAY_W-1:0] lowest_way(input logic [NUM_WAYS-1:0] m);
      lowest_way = '0;
      for (int i = NUM_WAYS - 1; i >= 0; i--) begin
         if (m[i]) lowest_way = WAY_W'(i);
      end
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dmask_q <= '0;
         vmask_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dmask_q <= dmask_d;
         vmask_q <= vmask_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      dmask_d        = dmask_q;
      vmask_d        = vmask_q;
      flush_ack_o    = 1'b0;
      tag_req_o      = 1'b0;
      wb_req_o       = 1'b0;
      inv_o          = 1'b0;
      inv_way_mask_o = '0;

      case (state_q)
         IDLE: begin
            if (flush_i) begin
               state_d = READ_TAG;
               cnt_d   = '0;
            end
         end
         READ_TAG: begin
            tag_req_o = 1'b1;
            if (tag_gnt_i) state_d = WAIT_TAG;
         end
         WAIT_TAG: begin
            // Only valid lines can need a write-back; stale dirty bits are ignored.
            dmask_d = dirty_i & valid_i;
            vmask_d = valid_i;
            state_d = (|(dirty_i & valid_i)) ? WB_REQ : INVALIDATE;
         end
         WB_REQ: begin
            wb_req_o = 1'b1;
            if (wb_gnt_i) state_d = WB_WAIT;
         end
         WB_WAIT: begin
            if (wb_done_i) begin
               dmask_d = dmask_q & (dmask_q - NUM_WAYS'(1));
               state_d = (|(dmask_q & (dmask_q - NUM_WAYS'(1)))) ? WB_REQ : INVALIDATE;
            end
         end
         INVALIDATE: begin
            inv_o          = 1'b1;
            inv_way_mask_o = vmask_q;
            if (cnt_q == IDX_W'(NUM_SETS - 1)) begin
               state_d = ACK;
            end else begin
               cnt_d   = cnt_q + IDX_W'(1);
               state_d = READ_TAG;
            end
         end
         ACK: begin
            flush_ack_o = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            // The requester keeps flush_i high one cycle past ack; do not restart on it.
            if (!flush_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (clr_i) begin
         state_d = IDLE;
         cnt_d   = '0;
         dmask_d = '0;
         vmask_d = '0;
      end
   end

   assign busy_o    = (state_q != IDLE) && (state_q != DONE);
   assign tag_idx_o = cnt_q;
   assign wb_way_o  = lowest_way(dmask_q);

endmodule
